wt_cpa_pipe: RTL and testbench

Two-stage pipelined carry-propagate adder that resolves the carry-save (sum/carry) vectors produced by the final 3:2 compressor row of the Wallace-tree multiplier into a binary product. It sits directly downstream of the compressor array and upstream of the product register/consumer. It provides a valid/ready handshake with full-throughput backpressure.

---
 rtl/wt_pkg.sv | 12 +
 rtl/wt_ripple_add.sv | 28 ++
 rtl/wt_cpa_pipe.sv | 92 +++++++++
 tb/tb_wt_cpa_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/wt_pkg.sv
// Shared constants and the 3:2 compressor cell for the Wallace-tree multiplier datapath.
package wt_pkg;

    localparam int W_DEF = 16;
    localparam int H_DEF = W_DEF / 2;

    // 3:2 compressor: returns {carry, sum} of three equally weighted bits.
    function automatic logic [1:0] csa32(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/wt_ripple_add.sv
// N-bit ripple-carry adder built from a chain of 3:2 compressor cells; purely combinational.
module wt_ripple_add
    import wt_pkg::*;
#(
    parameter int N = H_DEF
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    always_comb begin : ripple
        logic       c;
        logic [1:0] r;
        c   = cin;
        r   = '0;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            r      = csa32(a[i], b[i], c);
            sum[i] = r[0];
            c      = r[1];
        end
        cout = c;
    end

endmodule

// File: rtl/wt_cpa_pipe.sv
// Two-stage carry-propagate adder resolving the compressor sum/carry vectors into a binary product.
module wt_cpa_pipe
    import wt_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_sum,
    input  logic [W-1:0] in_carry,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_ovf
);

    localparam int H = W / 2;

    // Handshake: a beat moves on a rising edge only when valid && ready are both high;
    // valid never waits on ready, and the producer holds its data until the beat is taken.

    logic [W-1:0] b;
    logic [H-1:0] lo_res;
    logic         lo_cout;
    logic [H-1:0] hi_res;
    logic         hi_cout;
    logic         stall;

    logic         s1_valid;
    logic [H-1:0] s1_lo;
    logic         s1_cmid;
    logic [H-1:0] s1_hi_sum;
    logic [H-1:0] s1_hi_b;
    logic         s1_ctop;

    // The carry vector is one weight up; its MSB falls off the W-bit result into ovf.
    assign b        = {in_carry[W-2:0], 1'b0};
    assign stall    = out_valid && !out_ready;
    assign in_ready = rst_n && (!s1_valid || !stall);

    wt_ripple_add #(.N(H)) u_add_lo (
        .a    (in_sum[H-1:0]),
        .b    (b[H-1:0]),
        .cin  (1'b0),
        .sum  (lo_res),
        .cout (lo_cout)
    );

    wt_ripple_add #(.N(H)) u_add_hi (
        .a    (s1_hi_sum),
        .b    (s1_hi_b),
        .cin  (s1_cmid),
        .sum  (hi_res),
        .cout (hi_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_lo     <= '0;
            s1_cmid   <= 1'b0;
            s1_hi_sum <= '0;
            s1_hi_b   <= '0;
            s1_ctop   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (!stall) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= {hi_res, s1_lo};
                    out_ovf  <= hi_cout | s1_ctop;
                end
            end
            // S1 refills whenever its content moves on or it is empty.
            if (!stall || !s1_valid) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_lo     <= lo_res;
                    s1_cmid   <= lo_cout;
                    s1_hi_sum <= in_sum[W-1:H];
                    s1_hi_b   <= b[W-1:H];
                    s1_ctop   <= in_carry[W-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_wt_cpa_pipe.sv
// Directed and random checks of wt_cpa_pipe: latency, overflow, streaming, backpressure, reset.
module tb_wt_cpa_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_sum;
    logic [W-1:0] in_carry;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;

    int tests = 0;
    int fails = 0;

    logic [W:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [W:0] prev_out = '0;

    wt_cpa_pipe #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W:0] ref_sum(input logic [W-1:0] s, input logic [W-1:0] c);
        logic [W+1:0] full;
        full = {2'b00, s} + {1'b0, c, 1'b0};
        return {full[W+1:W] != 2'b00, full[W-1:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic vec(input string tag, input logic [W-1:0] s, input logic [W-1:0] c,
                       input logic [W-1:0] exp_data, input logic exp_ovf);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sum    = s;
        in_carry  = c;
        step();
        in_valid = 1'b0;
        step();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp_data));
        check({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
        step();
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (prev_stall) begin
                check("hold_stable", {31'(out_valid), 1'b0} | 32'({out_ovf, out_data} == prev_out),
                      32'h3);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra_output", 32'(out_data), 32'hDEAD_0000);
                end else begin
                    check("sb_result", 32'({out_ovf, out_data}), 32'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_sum(in_sum, in_carry));
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_ovf, out_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_carry  = '0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        vec("cross_half", 16'h00FF, 16'h0001, 16'h0101, 1'b0);
        vec("ovf_sum", 16'hFFFF, 16'h0001, 16'h0001, 1'b1);
        vec("ovf_carry", 16'h0000, 16'h8000, 16'h0000, 1'b1);

        // Streaming: 8 back-to-back pairs, results one cycle behind with no bubbles.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                in_valid = 1'b1;
                in_sum   = 16'(i * 16'h1111);
                in_carry = 16'(i);
                #1;
                check("stream_in_ready", 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 1 && i <= 8) begin
                check("stream_valid", 32'(out_valid), 32'd1);
                check("stream_data", 32'(out_data), 32'(16'((i - 1) * 16'h1111 + 2 * (i - 1))));
            end
        end
        check("stream_drained", 32'(out_valid), 32'd0);

        // Backpressure: out_ready low for 3 cycles while the source keeps offering.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sum    = 16'h0123;
        in_carry  = 16'h0001;
        #1;
        check("bp_ready0", 32'(in_ready), 32'd1);
        step();
        in_sum   = 16'h1123;
        in_carry = 16'h0002;
        #1;
        check("bp_ready1", 32'(in_ready), 32'd1);
        step();
        in_sum   = 16'h2123;
        in_carry = 16'h0003;
        #1;
        check("bp_ready_full", 32'(in_ready), 32'd0);
        check("bp_hold0", 32'(out_data), 32'h0125);
        step();
        out_ready = 1'b1;
        #1;
        check("bp_hold1", 32'(out_data), 32'h0125);
        check("bp_ready_resume", 32'(in_ready), 32'd1);
        step();
        check("bp_item1", 32'(out_data), 32'h1127);
        in_sum   = 16'h3123;
        in_carry = 16'h0004;
        step();
        check("bp_item2", 32'(out_data), 32'h2129);
        in_valid = 1'b0;
        step();
        check("bp_item3", 32'(out_data), 32'h312B);
        step();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Reset with two transfers in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sum    = 16'h4444;
        in_carry  = 16'h0011;
        step();
        in_sum   = 16'h5555;
        in_carry = 16'h0022;
        step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        exp_q.delete();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);
        vec("post_rst", 16'h0100, 16'h0080, 16'h0200, 1'b0);
        check("post_rst_no_stale", 32'(out_valid), 32'd0);

        // Random traffic with random backpressure; the scoreboard checks every result.
        repeat (1000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sum    = W'($urandom);
            in_carry  = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
